// File: rtl/logic_gate_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : logic_gate_unit                                              |
// | Description : Registered WIDTH-bit multi-function two-input gate           |
// |               (AND/OR/XOR/NAND/NOR/XNOR/NOT A/BUF A) with valid/ready on   |
// |               both sides and a one-deep output register. A built-in sweep  |
// |               sequencer drives vectors 00,01,10,11 through a selected op,  |
// |               streams the results out and captures the 4-bit truth table.  |
// | Ports       : clk, rst (sync, active-high)                                 |
// |               in_valid/in_ready/in_a/in_b/in_op   - operand side           |
// |               out_valid/out_ready/out_y/out_sweep - result side            |
// |               sweep_start/sweep_busy/sweep_done/sweep_tt - sweep control   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module logic_gate_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_sweep,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [3:0]       sweep_tt
);

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_ISSUE = 2'd1;
    localparam logic [1:0] C_ST_DRAIN = 2'd2;
    localparam logic [1:0] C_ST_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [2:0]       r_sweep_op;
    logic [1:0]       r_issue_cnt;
    logic [1:0]       r_drain_cnt;
    logic [3:0]       r_sweep_tt;
    logic             r_out_valid;
    logic             r_out_sweep;
    logic [WIDTH-1:0] r_out_y;

    logic             w_load_ok;
    logic             w_out_xfer;
    logic             w_ext_load;
    logic             w_sweep_load;
    logic             w_sweep_begin;
    logic             w_capture;
    logic [WIDTH-1:0] w_vec_a;
    logic [WIDTH-1:0] w_vec_b;

    function automatic logic [WIDTH-1:0] gate_eval(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] y;
        case (op)
            3'd0:    y = a & b;
            3'd1:    y = a | b;
            3'd2:    y = a ^ b;
            3'd3:    y = ~(a & b);
            3'd4:    y = ~(a | b);
            3'd5:    y = ~(a ^ b);
            3'd6:    y = ~a;
            default: y = a;
        endcase
        return y;
    endfunction

    // Output register can take a new value when empty or draining this cycle.
    assign w_load_ok     = !r_out_valid || out_ready;
    assign w_out_xfer    = r_out_valid && out_ready;
    assign in_ready      = (r_state == C_ST_IDLE) && !sweep_start && w_load_ok;
    assign w_ext_load    = in_valid && in_ready;
    assign w_sweep_load  = (r_state == C_ST_ISSUE) && w_load_ok;
    assign w_sweep_begin = (r_state == C_ST_IDLE) && sweep_start;
    // Only sweep-tagged results feed the truth table; a leftover external
    // result draining after sweep start carries out_sweep=0 and is skipped.
    assign w_capture     = w_out_xfer && r_out_sweep &&
                           ((r_state == C_ST_ISSUE) || (r_state == C_ST_DRAIN));

    // Vector i = {a,b}: every bit of a is i[1], every bit of b is i[0].
    assign w_vec_a = {WIDTH{r_issue_cnt[1]}};
    assign w_vec_b = {WIDTH{r_issue_cnt[0]}};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_IDLE:  if (sweep_start) w_state_nxt = C_ST_ISSUE;
            C_ST_ISSUE: if (w_load_ok && (r_issue_cnt == 2'd3)) w_state_nxt = C_ST_DRAIN;
            C_ST_DRAIN: if (w_capture && (r_drain_cnt == 2'd3)) w_state_nxt = C_ST_DONE;
            C_ST_DONE:  w_state_nxt = C_ST_IDLE;
            default:    w_state_nxt = C_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sweep_op  <= 3'd0;
            r_issue_cnt <= 2'd0;
            r_drain_cnt <= 2'd0;
            r_sweep_tt  <= 4'd0;
        end else if (w_sweep_begin) begin
            r_sweep_op  <= in_op;
            r_issue_cnt <= 2'd0;
            r_drain_cnt <= 2'd0;
            r_sweep_tt  <= 4'd0;
        end else begin
            if (w_sweep_load) begin
                r_issue_cnt <= r_issue_cnt + 2'd1;
            end
            if (w_capture) begin
                r_sweep_tt[r_drain_cnt] <= r_out_y[0];
                r_drain_cnt             <= r_drain_cnt + 2'd1;
            end
        end
    end

    // External loads only happen in IDLE and sweep loads only in ISSUE, so the
    // two load sources never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sweep <= 1'b0;
            r_out_y     <= '0;
        end else if (w_ext_load) begin
            r_out_valid <= 1'b1;
            r_out_sweep <= 1'b0;
            r_out_y     <= gate_eval(in_op, in_a, in_b);
        end else if (w_sweep_load) begin
            r_out_valid <= 1'b1;
            r_out_sweep <= 1'b1;
            r_out_y     <= gate_eval(r_sweep_op, w_vec_a, w_vec_b);
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_out_sweep <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_y      = r_out_y;
    assign out_sweep  = r_out_sweep;
    assign sweep_busy = (r_state == C_ST_ISSUE) || (r_state == C_ST_DRAIN);
    assign sweep_done = (r_state == C_ST_DONE);
    assign sweep_tt   = r_sweep_tt;

endmodule
`default_nettype wire

// File: doc/logic_gate_unit.md
Name: logic_gate_unit

Overview:
- Parametrised, registered multi-function two-input gate. One unit replaces the fixed single-bit gates: WIDTH-bit bitwise AND/OR/XOR/NAND/NOR/XNOR/NOT/BUF, selected per transaction.
- Valid/ready handshake on both input and output, with one output register stage.
- Built-in sweep sequencer applies the four input combinations 00, 01, 10, 11 to a selected op, streams the results out, and captures the op's 4-bit truth table for self-check.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  external operand valid.
- in_ready  out  1  unit accepts an external operand this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  3  op select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A, 7 BUF A. Also the sweep op when sweep_start is high.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_y  out  WIDTH  registered result.
- out_sweep  out  1  the current result was produced by the sweep sequencer.
- sweep_start  in  1  single-cycle request to start a sweep.
- sweep_busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse when a sweep completes.
- sweep_tt  out  4  captured truth table; bit k is the result for vector k = {a,b}.

Behaviour:
- Reset, synchronous and active-high, wins over everything. On reset: out_valid=0, out_y=0, out_sweep=0, sweep_busy=0, sweep_done=0, sweep_tt=0, FSM=IDLE, issue counter=0, drain counter=0. Reset mid-sweep aborts the sweep with no sweep_done pulse.
- Output stage:
  - 1-deep register.
  - load_ok = !out_valid || out_ready.
  - A load writes out_y = f(op, a, b) and sets out_valid=1.
  - If out_valid && out_ready and there is no load that cycle, out_valid clears next edge.
  - out_y holds its value while out_valid=1 and out_ready=0.
- Latency: 1 cycle from accepted input to out_valid. Full throughput of 1 result per cycle when out_ready=1.
- Ops: applied bitwise across all WIDTH bits. NOT A and BUF A ignore in_b.
- in_ready = (FSM==IDLE) && !sweep_start && load_ok. An external transfer is in_valid && in_ready.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: sweep_start=1 latches in_op into sweep_op, clears sweep_tt and both counters, sets sweep_busy=1, and goes to ISSUE. When sweep_start and in_valid are both high, sweep_start wins and the external operand is not accepted.
  - ISSUE: when load_ok, load vector i = issue counter with a={WIDTH{i[1]}}, b={WIDTH{i[0]}}, op=sweep_op, out_sweep=1, then increment the counter. After loading vector 3, go to DRAIN.
  - ISSUE and DRAIN: on each output transfer with out_sweep=1, set sweep_tt[drain counter]=out_y[0] and increment the drain counter. When the transfer of vector 3 completes, go to DONE.
  - DONE: assert sweep_done for exactly one cycle, clear sweep_busy, return to IDLE. sweep_tt holds until the next sweep_start or reset.
- sweep_start is ignored while sweep_busy=1 or in DONE.
- Backpressure: the sweep advances only on loads. With out_ready stuck at 0, the sweep stalls indefinitely with no vector dropped or repeated.
- In-flight external result at sweep start: it drains normally with out_sweep=0 and is not captured into sweep_tt.
- Counters are 2-bit. A wrap to 0 after vector 3 is not observable because the FSM has already left ISSUE/DRAIN.
- Expected truth tables (bit3..bit0): AND 1000, OR 1110, XOR 0110, NAND 0111, NOR 0001, XNOR 1001, NOT A 0011, BUF A 1100.

Test Plan:
- Directed ops, WIDTH=8, out_ready=1: a=0xF0, b=0xCC for ops 0..7 -> out_y = C0, FC, 3C, 3F, 03, C3, 0F, F0, each 1 cycle after acceptance.
- Sweep of each op 0..7, out_ready=1 -> 4 results with out_sweep=1 on consecutive cycles, sweep_done pulses once, sweep_tt matches the table above (AND=4'b1000).
- Sweep of XOR with out_ready toggling 1,0,0,1,0,1,... -> out_y sequence 00, FF, FF, 00 with no drop or duplicate, sweep_tt=4'b0110, sweep_busy high throughout.
- Backpressure on external path: out_ready=0 with a held result -> out_y stable, in_ready=0. Release -> the next operand loads in the same cycle as the drain.
- sweep_start and in_valid high in the same cycle in IDLE -> in_ready=0 and the operand is not consumed. A second sweep_start during the sweep is ignored, giving exactly 4 sweep results.
- Reset asserted after 2 sweep vectors -> next cycle out_valid=0, sweep_busy=0, sweep_tt=0, no sweep_done. A subsequent sweep runs correctly.
